// File: rtl/amp_scaler.sv
// amp_scaler: maps an amplitude sample to a TFT row coordinate,
// scaled against the running full-scale reference from max_find.
// The multiply is exact. A restoring divider then produces one quotient
// bit per cycle, MSB first, and the quotient is clamped to HEIGHT-1.
// Optional build macro AMP_SCALER_INVERT_EN: when defined, the output
// row is HEIGHT-1-q, which puts the origin at the top of the screen.
module amp_scaler #(
  parameter int DATA_W = 8,
  parameter int HEIGHT = 272,
  parameter int OUT_W  = 9
) (
  input  logic              clock,
  input  logic              aclr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] sample,
  input  logic [DATA_W-1:0] wmax,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_y,
  output logic              out_sat
);

  localparam int P     = DATA_W + OUT_W;
  localparam int CNT_W = $clog2(P);
  localparam logic [P-1:0]     FULL_P = P'(HEIGHT - 1);
  localparam logic [OUT_W-1:0] FULL_Y = OUT_W'(HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  // Control and output registers (reset)
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [OUT_W-1:0]   out_y_q, out_y_d;
  logic               out_sat_q, out_sat_d;

  // Datapath registers (no reset: always loaded before use)
  logic [DATA_W-1:0]  sample_q, sample_d;
  logic [DATA_W-1:0]  wmax_q, wmax_d;
  logic [DATA_W:0]    rem_q, rem_d;
  logic [P-1:0]       quot_q, quot_d;

  // Combinational helpers
  logic [P-1:0]       prod;
  logic [DATA_W:0]    trial;
  logic [DATA_W:0]    diff;
  logic               ge;
  logic [DATA_W:0]    rem_step;
  logic [P-1:0]       quot_step;
  logic [OUT_W:0]     res_c;

  // Clamp the full quotient to the visible range; a zero reference gives 0.
  // Result is {sat, y}.
  function automatic logic [OUT_W:0] sat_clamp(input logic [P-1:0] q,
                                               input logic zero_div);
    logic [OUT_W:0] r;
    if (zero_div) begin
      r = '0;
    end else if (q > FULL_P) begin
      r = {1'b1, FULL_Y};
    end else begin
      r = {1'b0, q[OUT_W-1:0]};
    end
    return r;
  endfunction

  // Choose the screen origin: bottom (identity) or top (mirrored).
  function automatic logic [OUT_W-1:0] orient(input logic [OUT_W-1:0] y);
`ifdef AMP_SCALER_INVERT_EN
    return FULL_Y - y;
`else
    return y;
`endif
  endfunction

  // Exact product and one restoring-division step.
  // The quotient register starts out holding the numerator and shifts its
  // MSB into the remainder. rem_q[DATA_W] is normally zero, but it is
  // still honoured so that the step stays correct if it is ever set.
  always_comb begin
    prod      = {{OUT_W{1'b0}}, sample_q} * FULL_P;
    trial     = {rem_q[DATA_W-1:0], quot_q[P-1]};
    ge        = rem_q[DATA_W] | (trial >= {1'b0, wmax_q});
    diff      = trial - {1'b0, wmax_q};
    rem_step  = ge ? diff : trial;
    quot_step = {quot_q[P-2:0], ge};
  end

  // Next-state logic for the IDLE/MUL/DIV/DONE sequence and its datapath
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_y_d     = out_y_q;
    out_sat_d   = out_sat_q;
    sample_d    = sample_q;
    wmax_d      = wmax_q;
    rem_d       = rem_q;
    quot_d      = quot_q;
    res_c       = '0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sample_d = sample;
          wmax_d   = wmax;
          state_d  = MUL;
        end
      end
      MUL: begin
        quot_d  = prod;
        rem_d   = '0;
        cnt_d   = CNT_W'(P - 1);
        state_d = DIV;
      end
      DIV: begin
        rem_d  = rem_step;
        quot_d = quot_step;
        if (cnt_q == '0) begin
          res_c       = sat_clamp(quot_step, wmax_q == '0);
          out_y_d     = orient(res_c[OUT_W-1:0]);
          out_sat_d   = res_c[OUT_W];
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // Control and output flops; reset aborts any computation in flight
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_y_q     <= out_y_d;
      out_sat_q   <= out_sat_d;
    end
  end

  // Input snapshot, product and divider registers
  always_ff @(posedge clock) begin
    sample_q <= sample_d;
    wmax_q   <= wmax_d;
    rem_q    <= rem_d;
    quot_q   <= quot_d;
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_amp_scaler.sv
// Testbench for amp_scaler (default parameters). Expected results come
// from an integer reference model and are queued at acceptance, then
// popped when the DUT presents its output.
module tb_amp_scaler;

  localparam int DATA_W = 8;
  localparam int HEIGHT = 272;
  localparam int OUT_W  = 9;

  logic              clock = 1'b0;
  logic              aclr = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] sample = '0;
  logic [DATA_W-1:0] wmax = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [OUT_W-1:0]  out_y;
  logic              out_sat;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  logic [OUT_W:0] exp_q[$];

  amp_scaler #(.DATA_W(DATA_W), .HEIGHT(HEIGHT), .OUT_W(OUT_W)) dut (
    .clock(clock), .aclr(aclr), .in_valid(in_valid), .in_ready(in_ready),
    .sample(sample), .wmax(wmax), .out_valid(out_valid),
    .out_ready(out_ready), .out_y(out_y), .out_sat(out_sat)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Reference model: returns {sat, y}
  function automatic logic [OUT_W:0] model(input int s, input int w);
    int q;
    logic sat;
    if (w == 0) begin
      q = 0;
      sat = 1'b0;
    end else begin
      q = (s * (HEIGHT - 1)) / w;
      sat = (q > HEIGHT - 1);
      if (sat) q = HEIGHT - 1;
    end
`ifdef AMP_SCALER_INVERT_EN
    q = HEIGHT - 1 - q;
`endif
    return {sat, OUT_W'(q)};
  endfunction

  // Present a pair and wait for the accepting edge; the expectation is
  // queued at that edge. Returns #1 after the accepting edge.
  task automatic send(input logic [DATA_W-1:0] s, input logic [DATA_W-1:0] w,
                      input bit hold, output bit ok);
    ok = 1'b0;
    sample = s;
    wmax = w;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      @(posedge clock);
      exp_q.push_back(model(int'(s), int'(w)));
      #1;
    end
    if (!hold) in_valid = 1'b0;
  endtask

  // Wait for out_valid; lat is the number of edges waited.
  task automatic wait_out(output int lat, output bit ok);
    ok = 1'b0;
    lat = 0;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clock);
      #1;
      if (out_valid === 1'b1) begin
        lat = n;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    aclr = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_cmp++;
    if (out_y !== '0) begin n_err++; $display("FAIL reset_out_y: got %0d expected 0", out_y); end
    n_cmp++;
    if (out_sat !== 1'b0) begin n_err++; $display("FAIL reset_out_sat: got %b expected 0", out_sat); end
    @(negedge clock);
    aclr = 1'b0;
  endtask

  // Basic, full scale, zero, zero reference and saturation cases
  task automatic test_vectors();
    logic [DATA_W-1:0] tab_s[6] = '{8'd128, 8'd255, 8'd0, 8'd77, 8'd200, 8'd101};
    logic [DATA_W-1:0] tab_w[6] = '{8'd255, 8'd255, 8'd255, 8'd0, 8'd100, 8'd100};
    logic [OUT_W:0] e;
    int lat;
    bit ok;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send(tab_s[i], tab_w[i], 1'b0, ok);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL vec_accept[%0d]: in_ready never high", i); continue; end
      wait_out(lat, ok);
      e = exp_q.pop_front();
      n_cmp++;
      if (!ok || lat != 18) begin
        n_err++; $display("FAIL vec_latency[%0d]: got %0d edges (seen=%0d) expected 18", i, lat, ok);
      end
      n_cmp++;
      if ({out_sat, out_y} !== e) begin
        n_err++;
        $display("FAIL vec_result[%0d]: got y=%0d sat=%b expected y=%0d sat=%b",
                 i, out_y, out_sat, e[OUT_W-1:0], e[OUT_W]);
      end
      @(posedge clock);
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_err++; $display("FAIL vec_pulse[%0d]: got out_valid=%b in_ready=%b expected 0/1", i, out_valid, in_ready);
      end
    end
  endtask

  // Hold out_ready low on a result; inputs changed mid-computation
  task automatic test_backpressure();
    logic [OUT_W:0] e;
    int lat;
    bit ok;
    out_ready = 1'b0;
    send(8'd128, 8'd255, 1'b0, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL bp_accept: in_ready never high"); out_ready = 1'b1; return; end
    repeat (3) @(posedge clock);
    #1;
    sample = 8'd7;
    wmax = 8'd3;
    wait_out(lat, ok);
    e = exp_q.pop_front();
    n_cmp++;
    if (!ok || lat + 3 != 18) begin n_err++; $display("FAIL bp_latency: got %0d expected 18", lat + 3); end
    n_cmp++;
    if ({out_sat, out_y} !== e) begin
      n_err++; $display("FAIL bp_result: got y=%0d sat=%b expected y=%0d sat=%b", out_y, out_sat, e[OUT_W-1:0], e[OUT_W]);
    end
    for (int k = 0; k < 5; k++) begin
      @(posedge clock);
      #1;
      n_cmp++;
      if (out_valid !== 1'b1 || out_y !== e[OUT_W-1:0] || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: got valid=%b y=%0d in_ready=%b expected 1/%0d/0",
                 k, out_valid, out_y, in_ready, e[OUT_W-1:0]);
      end
    end
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL bp_release: got valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
    end
  endtask

  // in_valid held high, random pairs, results every P+3 cycles
  task automatic test_back_to_back();
    logic [OUT_W:0] e;
    logic [DATA_W-1:0] s, w;
    int lat, prev_t;
    bit ok;
    prev_t = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      s = DATA_W'($urandom_range(0, 255));
      w = DATA_W'($urandom_range(0, 255));
      send(s, w, 1'b1, ok);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL b2b_accept[%0d]: in_ready never high", i); break; end
      wait_out(lat, ok);
      e = exp_q.pop_front();
      n_cmp++;
      if (!ok || {out_sat, out_y} !== e) begin
        n_err++;
        $display("FAIL b2b_result[%0d]: s=%0d w=%0d got y=%0d sat=%b expected y=%0d sat=%b",
                 i, s, w, out_y, out_sat, e[OUT_W-1:0], e[OUT_W]);
      end
      if (i > 0) begin
        n_cmp++;
        if (cyc - prev_t != 20) begin n_err++; $display("FAIL b2b_spacing[%0d]: got %0d expected 20", i, cyc - prev_t); end
      end
      prev_t = cyc;
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
  endtask

  // Reset asserted in DIV discards the sample; next sample is normal
  task automatic test_reset_mid_div();
    logic [OUT_W:0] e;
    int lat, seen;
    bit ok;
    out_ready = 1'b1;
    send(8'd255, 8'd255, 1'b0, ok);
    wait_out(lat, ok);
    e = exp_q.pop_front();
    n_cmp++;
    if (!ok || {out_sat, out_y} !== e) begin
      n_err++; $display("FAIL rst_pre_result: got y=%0d sat=%b expected y=%0d sat=%b", out_y, out_sat, e[OUT_W-1:0], e[OUT_W]);
    end
    @(posedge clock);
    #1;
    send(8'd200, 8'd50, 1'b0, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL rst_accept: in_ready never high"); end
    else void'(exp_q.pop_front());
    repeat (8) @(posedge clock);
    #1;
    aclr = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_y !== '0 || out_sat !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_values: got in_ready=%b valid=%b y=%0d sat=%b expected 1/0/0/0",
               in_ready, out_valid, out_y, out_sat);
    end
    @(negedge clock);
    aclr = 1'b0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock);
      #1;
      if (out_valid === 1'b1) seen++;
    end
    n_cmp++;
    if (seen != 0) begin n_err++; $display("FAIL rst_discard: got %0d valid cycles expected 0", seen); end
    send(8'd64, 8'd128, 1'b0, ok);
    wait_out(lat, ok);
    e = exp_q.pop_front();
    n_cmp++;
    if (!ok || lat != 18 || {out_sat, out_y} !== e) begin
      n_err++;
      $display("FAIL rst_post_result: got y=%0d sat=%b lat=%0d expected y=%0d sat=%b lat=18",
               out_y, out_sat, lat, e[OUT_W-1:0], e[OUT_W]);
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_div();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
